nmr_vote_ctrl: RTL and testbench

Parametrised N-modular-redundancy voter and recovery controller; successor to the fixed three-core voter in the TMR RISC-V top. Each valid cycle it takes one packed result bundle per core (PC, ALUResult, RD2, MemWrite), takes a word-level majority among the cores still in service, and registers the voted bundle toward memory and the PC controller. It tracks per-core fault counts, pulses a per-core resync request and holds the cores during a timed recovery window. It permanently excludes chronically faulty cores and enters a sticky FAIL state when no majority exists.

---
 rtl/nmr_pkg.sv | 16 +
 rtl/nmr_majority.sv | 58 +++++
 rtl/nmr_vote_ctrl.sv | 155 +++++++++++++++
 tb/tb_nmr_vote_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/nmr_pkg.sv
// Shared types and constants for the N-modular-redundancy voter.
package nmr_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StRecover = 2'd1,
        StFail    = 2'd2
    } nmr_state_e;

    localparam int unsigned PC_LSB  = 0;
    localparam int unsigned ALU_LSB = 32;
    localparam int unsigned RD2_LSB = 64;
    localparam int unsigned MW_BIT  = 96;
    localparam int unsigned CNT_W   = 4;

endpackage

// File: rtl/nmr_majority.sv
// Combinational word-level majority over the active cores: winner index,
// majority flag and the set of active cores that disagree with the winner.
module nmr_majority #(
    parameter int unsigned NUM_CORES = 3,
    parameter int unsigned WIDTH     = 97,
    localparam int unsigned IDX_W    = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES*WIDTH-1:0] core_bus,
    input  logic [NUM_CORES-1:0]       active_mask,
    output logic [IDX_W-1:0]           winner,
    output logic                       has_majority,
    output logic [NUM_CORES-1:0]       differ_mask
);

    localparam int unsigned CW = $clog2(NUM_CORES + 1);

    logic [WIDTH-1:0] bundle   [NUM_CORES];
    logic [CW-1:0]    agree    [NUM_CORES];
    logic [CW-1:0]    n_active;
    logic [CW-1:0]    maj;
    logic [WIDTH-1:0] win_bundle;

    always_comb begin
        n_active = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            bundle[i] = core_bus[i*WIDTH +: WIDTH];
            if (active_mask[i]) n_active = n_active + 1'b1;
        end
        maj = (n_active >> 1) + 1'b1;

        // Self-comparison supplies the "1 +" term for each active core.
        for (int i = 0; i < NUM_CORES; i++) begin
            agree[i] = '0;
            if (active_mask[i]) begin
                for (int j = 0; j < NUM_CORES; j++) begin
                    if (active_mask[j] && bundle[i] == bundle[j]) agree[i] = agree[i] + 1'b1;
                end
            end
        end

        winner       = '0;
        has_majority = 1'b0;
        win_bundle   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!has_majority && active_mask[i] && agree[i] >= maj) begin
                has_majority = 1'b1;
                winner       = IDX_W'(i);
                win_bundle   = bundle[i];
            end
        end

        differ_mask = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            differ_mask[i] = has_majority && active_mask[i] && (bundle[i] != win_bundle);
        end
    end

endmodule

// File: rtl/nmr_vote_ctrl.sv
// NMR voter and recovery controller: registers the voted bundle, tracks
// per-core fault counts, drives resync/hold and excludes chronic offenders.
module nmr_vote_ctrl
    import nmr_pkg::*;
#(
    parameter int unsigned NUM_CORES      = 3,
    parameter int unsigned WIDTH          = 97,
    parameter int unsigned FAULT_THRESH   = 4,
    parameter int unsigned RECOVER_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       main_rst,
    input  logic                       in_valid,
    input  logic [NUM_CORES*WIDTH-1:0] core_bus,
    output logic [WIDTH-1:0]           voted_bus,
    output logic                       voted_valid,
    output logic [NUM_CORES-1:0]       mismatch_mask,
    output logic [NUM_CORES-1:0]       excluded_mask,
    output logic [NUM_CORES-1:0]       core_resync,
    output logic                       core_hold,
    output logic                       no_majority,
    output logic [1:0]                 state
);

    localparam int unsigned IDX_W = $clog2(NUM_CORES);
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] Thresh = CNT_W'(FAULT_THRESH);
    localparam logic [7:0]       HoldLoad = 8'(RECOVER_CYCLES);

    nmr_state_e               state_q, state_d;
    logic [WIDTH-1:0]         voted_bus_q, voted_bus_d;
    logic                     voted_valid_q, voted_valid_d;
    logic [NUM_CORES-1:0]     mismatch_q, mismatch_d;
    logic [NUM_CORES-1:0]     excluded_q, excluded_d;
    logic [NUM_CORES-1:0]     resync_q, resync_d;
    logic                     hold_q, hold_d;
    logic                     no_maj_q, no_maj_d;
    logic [7:0]               hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]         cnt_q [NUM_CORES];
    logic [CNT_W-1:0]         cnt_d [NUM_CORES];

    logic [IDX_W-1:0]         winner;
    logic                     has_majority;
    logic [NUM_CORES-1:0]     differ_mask;
    logic [WIDTH-1:0]         win_bus;
    logic [3:0]               n_act;

    nmr_majority #(
        .NUM_CORES (NUM_CORES),
        .WIDTH     (WIDTH)
    ) u_majority (
        .core_bus     (core_bus),
        .active_mask  (~excluded_q),
        .winner       (winner),
        .has_majority (has_majority),
        .differ_mask  (differ_mask)
    );

    always_comb begin
        win_bus = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (winner == IDX_W'(i)) win_bus = core_bus[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d       = state_q;
        voted_bus_d   = voted_bus_q;
        voted_valid_d = 1'b0;
        mismatch_d    = mismatch_q;
        excluded_d    = excluded_q;
        resync_d      = '0;
        no_maj_d      = no_maj_q;
        hold_cnt_d    = hold_cnt_q;
        cnt_d         = cnt_q;
        n_act         = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!excluded_q[i]) n_act = n_act + 1'b1;
        end

        unique case (state_q)
            StRun: begin
                if (in_valid) begin
                    if (!has_majority) begin
                        no_maj_d = 1'b1;
                        state_d  = StFail;
                    end else begin
                        voted_bus_d   = win_bus;
                        voted_valid_d = 1'b1;
                        mismatch_d    = differ_mask;
                        if (|differ_mask) begin
                            resync_d   = differ_mask;
                            state_d    = StRecover;
                            hold_cnt_d = HoldLoad;
                            // Exclusions are granted in index order while at least two cores remain.
                            for (int i = 0; i < NUM_CORES; i++) begin
                                if (differ_mask[i]) begin
                                    cnt_d[i] = (cnt_q[i] == CntMax) ? CntMax : cnt_q[i] + 1'b1;
                                    if (cnt_d[i] >= Thresh && n_act > 4'd2) begin
                                        excluded_d[i] = 1'b1;
                                        n_act         = n_act - 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
            end
            StRecover: begin
                hold_cnt_d = hold_cnt_q - 1'b1;
                if (hold_cnt_q <= 8'd1) state_d = StRun;
            end
            StFail: ;
            default: state_d = StRun;
        endcase

        hold_d = (state_d != StRun);
    end

    always_ff @(posedge clk) begin
        if (main_rst) begin
            state_q       <= StRun;
            voted_bus_q   <= '0;
            voted_valid_q <= 1'b0;
            mismatch_q    <= '0;
            excluded_q    <= '0;
            resync_q      <= '0;
            hold_q        <= 1'b0;
            no_maj_q      <= 1'b0;
            hold_cnt_q    <= '0;
            for (int i = 0; i < NUM_CORES; i++) cnt_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            voted_bus_q   <= voted_bus_d;
            voted_valid_q <= voted_valid_d;
            mismatch_q    <= mismatch_d;
            excluded_q    <= excluded_d;
            resync_q      <= resync_d;
            hold_q        <= hold_d;
            no_maj_q      <= no_maj_d;
            hold_cnt_q    <= hold_cnt_d;
            for (int i = 0; i < NUM_CORES; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign voted_bus     = voted_bus_q;
    assign voted_valid   = voted_valid_q;
    assign mismatch_mask = mismatch_q;
    assign excluded_mask = excluded_q;
    assign core_resync   = resync_q;
    assign core_hold     = hold_q;
    assign no_majority   = no_maj_q;
    assign state         = state_q;

endmodule

// File: tb/tb_nmr_vote_ctrl.sv
// Directed bench for nmr_vote_ctrl: a 3-core instance for the voting, recovery,
// exclusion and fail paths, plus a 5-core instance for a split-vote case.
module tb_nmr_vote_ctrl;
    import nmr_pkg::*;

    localparam int unsigned W = 97;

    logic         clk = 1'b0;
    logic         main_rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] b [3];
    logic [3*W-1:0] core_bus;
    logic [W-1:0] voted_bus;
    logic         voted_valid, core_hold, no_majority;
    logic [2:0]   mismatch_mask, excluded_mask, core_resync;
    logic [1:0]   state;

    logic           in_valid5 = 1'b0;
    logic [5*W-1:0] core_bus5 = '0;
    logic [W-1:0]   voted_bus5;
    logic           voted_valid5, core_hold5, no_majority5;
    logic [4:0]     mismatch_mask5, excluded_mask5, core_resync5;
    logic [1:0]     state5;

    int n_checks = 0;
    int n_pass   = 0;
    int hold_cycles;

    always #5 clk = ~clk;
    assign core_bus = {b[2], b[1], b[0]};

    nmr_vote_ctrl #(.NUM_CORES(3)) dut (
        .clk (clk), .main_rst (main_rst), .in_valid (in_valid), .core_bus (core_bus),
        .voted_bus (voted_bus), .voted_valid (voted_valid), .mismatch_mask (mismatch_mask),
        .excluded_mask (excluded_mask), .core_resync (core_resync), .core_hold (core_hold),
        .no_majority (no_majority), .state (state)
    );

    nmr_vote_ctrl #(.NUM_CORES(5)) dut5 (
        .clk (clk), .main_rst (main_rst), .in_valid (in_valid5), .core_bus (core_bus5),
        .voted_bus (voted_bus5), .voted_valid (voted_valid5), .mismatch_mask (mismatch_mask5),
        .excluded_mask (excluded_mask5), .core_resync (core_resync5), .core_hold (core_hold5),
        .no_majority (no_majority5), .state (state5)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] mk(input logic [31:0] pc, input logic [31:0] alu);
        return {1'b0, 32'h0, alu, pc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One valid compare cycle with the given ALU results; returns at t+1.
    task automatic compare(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
        b[0] = mk(32'h10, a0);
        b[1] = mk(32'h10, a1);
        b[2] = mk(32'h10, a2);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_run();
        for (int k = 0; k < 20 && state != 2'd0; k++) step();
        check("recover_exit", state, 2'd0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) b[i] = '0;
        step();
        step();
        main_rst = 1'b0;
        check("rst_state", state, 2'd0);
        check("rst_valid", voted_valid, 1'b0);
        check("rst_bus", voted_bus, '0);
        check("rst_excl", excluded_mask, 3'b000);
        check("rst_hold", core_hold, 1'b0);

        // All cores agree
        compare(32'h4, 32'h4, 32'h4);
        check("agree_pc", voted_bus[PC_LSB +: 32], 32'h10);
        check("agree_valid", voted_valid, 1'b1);
        check("agree_mm", mismatch_mask, 3'b000);
        check("agree_state", state, 2'd0);
        step();
        check("idle_valid", voted_valid, 1'b0);

        // Core 1 disagrees: vote 4, resync pulse, 8-cycle hold
        compare(32'h4, 32'hDEAD_BEEF, 32'h4);
        check("mm1_alu", voted_bus[ALU_LSB +: 32], 32'h4);
        check("mm1_mask", mismatch_mask, 3'b010);
        check("mm1_resync", core_resync, 3'b010);
        check("mm1_state", state, 2'd1);
        hold_cycles = core_hold ? 1 : 0;
        step();
        check("mm1_resync_off", core_resync, 3'b000);
        for (int k = 0; k < 20 && core_hold; k++) begin
            hold_cycles++;
            step();
        end
        check("mm1_hold_len", hold_cycles, 8);
        check("mm1_back_run", state, 2'd0);

        // Core 2 mismatches four times -> excluded on the fourth
        for (int n = 0; n < 4; n++) begin
            compare(32'h4, 32'h4, 32'h1234 + n);
            check("c2_mask", mismatch_mask, 3'b100);
            check("c2_excl", excluded_mask, (n == 3) ? 3'b100 : 3'b000);
            if (n == 3) check("c2_resync_on_excl", core_resync, 3'b100);
            wait_run();
        end

        // Excluded core 2 differs alone: no mismatch, no hold
        compare(32'h4, 32'h4, 32'h999);
        check("ex_mask", mismatch_mask, 3'b000);
        check("ex_hold", core_hold, 1'b0);
        check("ex_valid", voted_valid, 1'b1);
        check("ex_state", state, 2'd0);

        // Two active cores disagree: no majority, sticky fail
        compare(32'h1, 32'h2, 32'h1);
        check("nm_flag", no_majority, 1'b1);
        check("nm_state", state, 2'd2);
        check("nm_valid", voted_valid, 1'b0);
        check("nm_hold", core_hold, 1'b1);
        for (int k = 0; k < 4; k++) compare(32'h4, 32'h4, 32'h4);
        check("nm_sticky_state", state, 2'd2);
        check("nm_sticky_flag", no_majority, 1'b1);
        check("nm_sticky_valid", voted_valid, 1'b0);

        main_rst = 1'b1;
        step();
        main_rst = 1'b0;
        check("frst_state", state, 2'd0);
        check("frst_excl", excluded_mask, 3'b000);
        check("frst_nomaj", no_majority, 1'b0);

        // Core 2 to count 3, then reset mid-recover; counts must clear
        for (int n = 0; n < 3; n++) begin
            compare(32'h4, 32'h4, 32'h77);
            wait_run();
        end
        compare(32'h4, 32'h5, 32'h4);
        step();
        step();
        check("rr_in_recover", state, 2'd1);
        main_rst = 1'b1;
        step();
        main_rst = 1'b0;
        check("rr_state", state, 2'd0);
        check("rr_hold", core_hold, 1'b0);
        check("rr_mask", mismatch_mask, 3'b000);
        compare(32'h4, 32'h4, 32'h77);
        check("rr_cnt_cleared", excluded_mask, 3'b000);
        wait_run();

        // Five cores: {0,1} vs {2,3,4}
        core_bus5 = {mk(32'h20, 32'h9), mk(32'h20, 32'h9), mk(32'h20, 32'h9),
                     mk(32'h20, 32'h1), mk(32'h20, 32'h1)};
        in_valid5 = 1'b1;
        step();
        in_valid5 = 1'b0;
        check("n5_mask", mismatch_mask5, 5'b00011);
        check("n5_bus", voted_bus5, mk(32'h20, 32'h9));
        check("n5_resync", core_resync5, 5'b00011);
        check("n5_state", state5, 2'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
